// File: rtl/simon_out_arbiter.sv
// Round-robin arbiter over R SIMON output packetizers; captures the granted
// packet and streams it MSB-byte-first onto one valid/ready byte channel.
module simon_out_arbiter #(
    parameter  int N  = 16,
    parameter  int R  = 4,
    localparam int PB = 2 + N / 2,
    localparam int RB = $clog2(R),
    localparam int IW = $clog2(PB)
) (
    input  logic                      clk,
    input  logic                      nR,
    input  logic [R-1:0]              doneIN,
    input  logic [R-1:0][PB-1:0][7:0] pktIN,
    output logic [R-1:0]              readIN,
    output logic [7:0]                txByte,
    output logic                      txValid,
    input  logic                      txReady,
    output logic [RB-1:0]             txSrc,
    output logic                      txLast,
    output logic                      busy
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [RB-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [PB-1:0][7:0]  buf_q, buf_d;
    logic [R-1:0]        read_q, read_d;
    logic                valid_q, valid_d;
    logic [RB-1:0]       src_q, src_d;

    logic                found;
    logic [RB-1:0]       gnt;
    logic [RB:0]         cand;

    // Scan from ptr upward with explicit wrap so non-power-of-2 R works.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int i = 0; i < R; i++) begin
            cand = {1'b0, ptr_q} + (RB+1)'(i);
            if (cand >= (RB+1)'(R)) cand = cand - (RB+1)'(R);
            if (!found && doneIN[cand[RB-1:0]]) begin
                found = 1'b1;
                gnt   = cand[RB-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        read_d  = '0;
        valid_d = valid_q;
        src_d   = src_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (found) begin
                    buf_d   = pktIN[gnt];
                    src_d   = gnt;
                    read_d  = R'(1) << gnt;
                    idx_d   = IW'(PB - 1);
                    valid_d = 1'b1;
                    ptr_d   = (gnt == RB'(R - 1)) ? '0 : gnt + 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // doneIN is deliberately ignored until the packet has drained.
                if (valid_q && txReady) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            read_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            read_q  <= read_d;
            valid_q <= valid_d;
            src_q   <= src_d;
        end
    end

    assign readIN  = read_q;
    assign txByte  = buf_q[idx_q];
    assign txValid = valid_q;
    assign txSrc   = src_q;
    assign txLast  = valid_q && (idx_q == '0);
    assign busy    = (state_q == SEND);
endmodule

// File: tb/tb_simon_out_arbiter.sv
// Bench for simon_out_arbiter: vector table plus hand sequences, bytes checked
// against a scoreboard queue filled when each request is driven.
module tb_simon_out_arbiter;
    localparam int N  = 16;
    localparam int R  = 4;
    localparam int PB = 2 + N / 2;

    logic                      clk = 1'b0;
    logic                      nR;
    logic [R-1:0]              doneIN;
    logic [R-1:0][PB-1:0][7:0] pktIN;
    logic [R-1:0]              readIN;
    logic [7:0]                txByte;
    logic                      txValid;
    logic                      txReady;
    logic [1:0]                txSrc;
    logic                      txLast;
    logic                      busy;

    simon_out_arbiter #(.N(N), .R(R)) dut (
        .clk(clk), .nR(nR), .doneIN(doneIN), .pktIN(pktIN), .readIN(readIN),
        .txByte(txByte), .txValid(txValid), .txReady(txReady), .txSrc(txSrc),
        .txLast(txLast), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] b; logic [1:0] s; logic last;} exp_t;
    typedef struct {logic [3:0] done; int src; bit bp; int cyc;} vec_t;

    exp_t      q[$];
    int        gseen[$];
    int        n_cmp = 0, n_bad = 0, n_acc = 0;
    bit        bp_mode = 0, rel_all = 0;
    int        bp_i = 0;
    logic [3:0] rel_mask = 4'hF;
    bit        bp_pat[6] = '{1, 0, 0, 1, 0, 1};
    bit        prev_stall = 0;
    logic [7:0] prev_byte;
    logic [1:0] prev_src;
    vec_t      vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_pkt(input int s, input int nbytes);
        exp_t e;
        for (int b = PB - 1; b >= PB - nbytes; b--) begin
            e.b = pktIN[s][b];
            e.s = 2'(s);
            e.last = (b == 0);
            q.push_back(e);
        end
    endtask

    // One clock: update ready pattern after the edge, observe at the negedge.
    task automatic cyc();
        exp_t e;
        @(posedge clk); #1;
        if (bp_mode) begin
            txReady = bp_pat[bp_i % 6];
            bp_i++;
        end
        @(negedge clk);
        if (!nR) return;
        if (prev_stall) begin
            chk("stall_valid", txValid, 1'b1);
            chk("stall_byte", txByte, prev_byte);
            chk("stall_src", txSrc, prev_src);
        end
        if (readIN != '0) begin
            chk("read_onehot", $countones(readIN), 1);
            for (int i = 0; i < R; i++) if (readIN[i]) gseen.push_back(i);
            if (rel_all) doneIN = '0;
            else doneIN = doneIN & ~(readIN & rel_mask);
        end
        if (txValid && txReady) begin
            if (q.size() == 0) begin
                chk("unexpected_byte", txByte, 8'hxx);
            end else begin
                e = q.pop_front();
                chk("byte", txByte, e.b);
                chk("src", txSrc, e.s);
                chk("last", txLast, e.last);
                n_acc++;
            end
        end
        prev_stall = txValid && !txReady;
        prev_byte  = txByte;
        prev_src   = txSrc;
    endtask

    task automatic wait_idle(input int max, input int exp_cyc);
        int n = 0;
        do begin
            cyc();
            n++;
        end while ((busy || doneIN != '0 || q.size() != 0) && n < max);
        if (n >= max) chk("timeout_idle", n, 0);
        if (exp_cyc > 0) chk("cycles", n, exp_cyc);
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{done: 4'b0100, src: 2, bp: 0, cyc: 11};
        vecs[1] = '{done: 4'b0011, src: 0, bp: 0, cyc: 11};
        vecs[2] = '{done: 4'b0011, src: 1, bp: 0, cyc: 11};
        vecs[3] = '{done: 4'b1001, src: 3, bp: 0, cyc: 11};
        vecs[4] = '{done: 4'b1010, src: 1, bp: 0, cyc: 11};
        vecs[5] = '{done: 4'b0001, src: 0, bp: 1, cyc: 0};
        vecs[6] = '{done: 4'b1000, src: 3, bp: 0, cyc: 11};

        for (int s = 0; s < R; s++)
            for (int b = 0; b < PB; b++) pktIN[s][b] = 8'(s * 16 + b + 8'h30);
        pktIN[2] = 80'hA1_00_0123_4567_89AB_CDEF;

        // Reset with every source requesting
        nR = 1'b0; doneIN = 4'hF; txReady = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_read", readIN, 4'h0);
        chk("rst_valid", txValid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_byte", txByte, 8'h00);
        chk("rst_src", txSrc, 2'd0);
        chk("rst_last", txLast, 1'b0);

        // Contention from ptr=0: grants 0,1,2,3 in 44 cycles
        gseen.delete();
        for (int s = 0; s < R; s++) push_pkt(s, PB);
        rel_mask = 4'hF; rel_all = 0;
        nR = 1'b1;
        wait_idle(200, 44);
        chk("contention_ngrants", gseen.size(), 4);
        if (gseen.size() == 4)
            for (int i = 0; i < 4; i++) chk("contention_order", gseen[i], i);

        // Single-request vectors, including the spec packet and backpressure
        rel_all = 1;
        foreach (vecs[v]) begin
            gseen.delete();
            bp_mode = vecs[v].bp; bp_i = 0;
            txReady = 1'b1;
            doneIN = vecs[v].done;
            push_pkt(vecs[v].src, PB);
            wait_idle(200, vecs[v].cyc);
            chk("vec_ngrants", gseen.size(), 1);
            if (gseen.size() == 1) chk("vec_src", gseen[0], vecs[v].src);
            bp_mode = 0; txReady = 1'b1;
        end

        // Fairness: src0 held high, src3 raised mid-packet -> 0,3,0
        rel_all = 0; rel_mask = 4'b1000;
        gseen.delete();
        push_pkt(0, PB); push_pkt(3, PB); push_pkt(0, PB);
        doneIN = 4'b0001;
        for (int n = 0; n < 300 && gseen.size() < 3; n++) begin
            cyc();
            if (gseen.size() == 1 && n == 3) doneIN[3] = 1'b1;
        end
        doneIN = '0;
        wait_idle(200, 0);
        chk("fair_ngrants", gseen.size(), 3);
        if (gseen.size() == 3) begin
            chk("fair_g0", gseen[0], 0);
            chk("fair_g1", gseen[1], 3);
            chk("fair_g2", gseen[2], 0);
        end

        // Reset after the 4th byte is accepted
        rel_all = 1; gseen.delete(); n_acc = 0;
        push_pkt(2, 4);
        doneIN = 4'b0100;
        for (int n = 0; n < 100 && n_acc < 4; n++) cyc();
        chk("mid_acc", n_acc, 4);
        @(posedge clk); #1;
        nR = 1'b0; #1;
        chk("mid_valid", txValid, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_read", readIN, 4'h0);
        chk("mid_last", txLast, 1'b0);
        chk("mid_byte", txByte, 8'h00);
        chk("mid_queue", q.size(), 0);
        prev_stall = 0;
        repeat (2) @(negedge clk);
        nR = 1'b1;
        gseen.delete();
        doneIN = 4'b1010;
        push_pkt(1, PB);
        wait_idle(200, 11);
        chk("post_rst_ngrants", gseen.size(), 1);
        if (gseen.size() == 1) chk("post_rst_src", gseen[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
